rr_arbiter16: RTL and testbench
===============================

# rr_arbiter16

Sixteen-requester round-robin arbiter that shares one downstream resource (bus, port or execution unit) among up to 16 clients. It is the sequential counterpart to the team's 16-to-4 priority encoder: each cycle it masks the request vector with a rotating priority pointer, encodes the winner, and registers a one-hot grant plus its 4-bit index. It holds the grant until the owner finishes, drops its request or exceeds a hold limit. It sits between client request lines and the shared-resource mux select.

## Interface

- MAX_HOLD, 16: maximum consecutive cycles one owner may hold the grant (legal range 2..65535).
- clk  input  1  single clock; all state updates on rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- req  input  16  request per client; bit i high = client i wants the resource.
- done  input  1  current owner ends its transaction this cycle; ignored when not busy.
- gnt  output  16  one-hot grant, registered; all zero when idle.
- gnt_id  output  4  binary index of the granted client; 0 when idle.
- busy  output  1  high while a grant is active.
- revoke  output  1  one-cycle pulse: grant was forcibly removed by hold timeout.

## Operation

- States: IDLE (no owner) and GRANT (owner = gnt_id).
- Internal state: ptr[3:0] (last granted index), hold counter hcnt (width clog2(MAX_HOLD)).
- Release condition in GRANT: done=1, or req[gnt_id]=0, or hcnt = MAX_HOLD-1 (timeout).
- Arbitration is evaluated in IDLE and in any GRANT cycle with a release.
  - cand = req, with the current owner's bit cleared when a release is occurring.
  - hi = cand with bits 0..ptr cleared. If hi is nonzero, the winner is the lowest set index in hi. Otherwise the winner is the lowest set index in cand.
  - If cand is nonzero: next state GRANT, gnt = onehot(winner), gnt_id = winner, ptr = winner, hcnt = 0.
  - If cand is zero: next state IDLE, gnt = 0, gnt_id = 0, busy = 0, ptr unchanged.
- GRANT without release: outputs hold and hcnt increments.
- revoke = 1 for exactly the cycle after a timeout release in which done=0 and req[gnt_id]=1. If done or a request drop coincides with the timeout, it is a normal release and revoke stays 0.
- Requests from non-owners never preempt the owner.
- Invariants: gnt has at most one bit set, and gnt is nonzero exactly when busy=1.

## Timing

- Reset (asynchronous assert, synchronous release): gnt=0, gnt_id=0, busy=0, revoke=0, hcnt=0, ptr=15, state IDLE. With ptr=15, client 0 has first priority after reset.
- Grant latency is 1 cycle: a request sampled at edge N in IDLE produces gnt at edge N+1.
- Back-to-back handoff has zero idle cycles: a release at edge N with other requests pending gives the new owner's gnt at N+1.
- A release with no other requesters returns to IDLE at N+1, even if the releasing owner still requests (its bit is excluded that cycle). It can win again at N+2.
- Maximum continuous ownership is MAX_HOLD cycles.
- Worst-case wait for a persistently requesting client is 15 × MAX_HOLD + 1 cycles.
- Reset asserted mid-grant clears all outputs immediately, without waiting for a clock edge.

## Structure

- Shared package rr_arb_pkg holds: N_REQ=16, ID_W=4, the state enum (IDLE, GRANT), and the reset value PTR_RST=4'd15.
- One sub-module, prio_enc16_lsb: combinational 16-to-4 lowest-index-first encoder with a valid output. It is instantiated twice, once for hi and once for cand. The RTL selects the hi result when its valid is set.
- All outputs are registered; there is no combinational path from req to gnt.

## Test plan

- Reset: hold resetn=0 with req=16'hFFFF -> gnt=0, gnt_id=0, busy=0, revoke=0. Release reset with req=16'hFFFF -> gnt=16'h0001 one cycle later.
- Single requester: req=16'h0100, pulse done after 3 cycles -> gnt=16'h0100 and gnt_id=8 for 4 cycles, then gnt=0 and busy=0.
- Fairness: req=16'hFFFF held, done pulsed every grant cycle -> gnt_id sequence 0,1,2,…,15,0 with no idle gaps.
- Timeout (MAX_HOLD=4): client 3 holds req and never asserts done, req[5]=1 -> client 3 granted 4 cycles, revoke pulse coincides with gnt=16'h0020. Client 3 is next granted only after client 5 releases.
- Simultaneous events: owner 7 asserts done while req=16'h0080 only -> IDLE for one cycle, then gnt_id=7 again. Same case with req[2]=1 -> next grant is 2, because 2 is lowest in cand after wrap.
- Mid-grant reset: assert resetn=0 while gnt_id=9 -> outputs clear asynchronously. After release with req=16'h0201 -> gnt_id=0 (ptr restored to 15).

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared definitions for the 16-requester round-robin arbiter slice.
package rr_arb_pkg;

    localparam int N_REQ = 16;
    localparam int ID_W  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Pointer starts at the top index so client 0 wins first after reset.
    localparam logic [ID_W-1:0] PTR_RST = 4'd15;

endpackage

// File: rtl/prio_enc16_lsb.sv
// Combinational 16-to-4 priority encoder: the lowest set index wins.
module prio_enc16_lsb
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    output logic [ID_W-1:0]  id,
    output logic             valid
);

    // Scan from the top down so the last assignment is the lowest set bit.
    always_comb begin
        id    = '0;
        valid = |req;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 clients with a hold limit and a registered
// one-hot grant plus binary index.
module rr_arbiter16
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             revoke
);

    localparam int HCNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(MAX_HOLD - 1);

    state_t            state, state_nxt;
    logic [ID_W-1:0]   ptr, ptr_nxt;
    logic [HCNT_W-1:0] hcnt, hcnt_nxt;
    logic [N_REQ-1:0]  gnt_nxt;
    logic [ID_W-1:0]   gnt_id_nxt;
    logic              busy_nxt;
    logic              revoke_nxt;

    logic              timeout;
    logic              owner_req;
    logic              release_now;
    logic [N_REQ-1:0]  cand;
    logic [N_REQ-1:0]  hi;
    logic [ID_W-1:0]   hi_id, cand_id, win;
    logic              hi_v, cand_v;

    // The owner's own bit is excluded while it releases, so a lone owner
    // that keeps requesting must sit out one idle cycle before winning again.
    always_comb begin
        timeout     = (state == GRANT) && (hcnt == HCNT_MAX);
        owner_req   = req[gnt_id];
        release_now = (state == GRANT) && (done || !owner_req || timeout);
        cand        = release_now ? (req & ~gnt) : req;
    end

    always_comb begin
        hi = '0;
        for (int i = 0; i < N_REQ; i++) begin
            hi[i] = cand[i] && (i > int'(ptr));
        end
    end

    prio_enc16_lsb u_enc_hi (
        .req   (hi),
        .id    (hi_id),
        .valid (hi_v)
    );

    prio_enc16_lsb u_enc_cand (
        .req   (cand),
        .id    (cand_id),
        .valid (cand_v)
    );

    assign win = hi_v ? hi_id : cand_id;

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        hcnt_nxt   = hcnt;
        gnt_nxt    = gnt;
        gnt_id_nxt = gnt_id;
        busy_nxt   = busy;
        revoke_nxt = timeout && !done && owner_req;

        if (state == IDLE || release_now) begin
            if (cand_v) begin
                state_nxt  = GRANT;
                gnt_nxt    = {{(N_REQ-1){1'b0}}, 1'b1} << win;
                gnt_id_nxt = win;
                ptr_nxt    = win;
                hcnt_nxt   = '0;
                busy_nxt   = 1'b1;
            end else begin
                state_nxt  = IDLE;
                gnt_nxt    = '0;
                gnt_id_nxt = '0;
                hcnt_nxt   = '0;
                busy_nxt   = 1'b0;
            end
        end else begin
            hcnt_nxt = hcnt + HCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            ptr    <= PTR_RST;
            hcnt   <= '0;
            gnt    <= '0;
            gnt_id <= '0;
            busy   <= 1'b0;
            revoke <= 1'b0;
        end else begin
            state  <= state_nxt;
            ptr    <= ptr_nxt;
            hcnt   <= hcnt_nxt;
            gnt    <= gnt_nxt;
            gnt_id <= gnt_id_nxt;
            busy   <= busy_nxt;
            revoke <= revoke_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter16.sv
// Directed and randomized bench for rr_arbiter16 against a rotating-search
// reference model of owner, pointer and hold time.
module tb_rr_arbiter16;

    localparam int MAX_HOLD = 4;

    logic        clk;
    logic        resetn;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  gnt_id;
    logic        busy;
    logic        revoke;

    int checks   = 0;
    int failures = 0;

    int mOwner;
    int mPtr;
    int mHeld;
    bit mRevoke;

    rr_arbiter16 #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk    (clk),
        .resetn (resetn),
        .req    (req),
        .done   (done),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy),
        .revoke (revoke)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mOwner  = -1;
        mPtr    = 15;
        mHeld   = 0;
        mRevoke = 0;
    endtask

    // One clock edge of the arbitration rules, using the inputs seen at that edge.
    task automatic modelStep(input logic [15:0] r, input logic d);
        bit          rel;
        bit          tout;
        bit          drop;
        logic [15:0] cand;
        int          winner;
        rel     = 0;
        mRevoke = 0;
        if (mOwner >= 0) begin
            tout    = (mHeld == MAX_HOLD - 1);
            drop    = !r[mOwner];
            rel     = d || drop || tout;
            mRevoke = tout && !d && !drop;
        end
        if (mOwner < 0 || rel) begin
            cand = r;
            if (mOwner >= 0) cand[mOwner] = 1'b0;
            winner = -1;
            for (int k = 1; k <= 16; k++) begin
                if (winner < 0 && cand[(mPtr + k) % 16]) winner = (mPtr + k) % 16;
            end
            mOwner = winner;
            mHeld  = 0;
            if (winner >= 0) mPtr = winner;
        end else begin
            mHeld++;
        end
    endtask

    task automatic checkOutput(input string tag);
        chk({tag, ".gnt"},    32'(gnt),    (mOwner >= 0) ? (32'h1 << mOwner) : 32'h0);
        chk({tag, ".gnt_id"}, 32'(gnt_id), (mOwner >= 0) ? 32'(mOwner) : 32'h0);
        chk({tag, ".busy"},   32'(busy),   32'(mOwner >= 0));
        chk({tag, ".revoke"}, 32'(revoke), 32'(mRevoke));
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic applyStimulus(input logic [15:0] r, input logic d, input string tag);
        req  = r;
        done = d;
        @(posedge clk);
        modelStep(r, d);
        #1;
        checkOutput(tag);
        @(negedge clk);
    endtask

    // Asynchronous assert right now, one edge held in reset, release at a falling edge.
    task automatic doReset(input logic [15:0] r, input string tag);
        req    = r;
        done   = 1'b0;
        resetn = 1'b0;
        modelReset();
        #1;
        checkOutput({tag, ".async"});
        @(posedge clk);
        #1;
        checkOutput({tag, ".held"});
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        req    = '0;
        done   = 1'b0;
        resetn = 1'b1;
        modelReset();
        @(negedge clk);

        doReset(16'hFFFF, "reset");
        applyStimulus(16'hFFFF, 1'b0, "reset_first");
        chk("reset_first_gnt", 32'(gnt), 32'h0001);
        applyStimulus(16'h0000, 1'b0, "drop_all");

        for (int i = 0; i < 4; i++) applyStimulus(16'h0100, 1'b0, "single");
        chk("single_id", 32'(gnt_id), 32'd8);
        applyStimulus(16'h0100, 1'b1, "single_done");
        chk("single_idle", 32'(busy), 32'd0);
        applyStimulus(16'h0000, 1'b0, "single_after");

        doReset(16'h0000, "fair_rst");
        for (int i = 0; i < 18; i++) begin
            applyStimulus(16'hFFFF, 1'b1, "fair");
            if (i < 17) chk("fair_seq", 32'(gnt_id), 32'(i % 16));
        end

        doReset(16'h0000, "tout_rst");
        for (int i = 0; i < 4; i++) applyStimulus(16'h0028, 1'b0, "tout_hold3");
        applyStimulus(16'h0028, 1'b0, "tout_edge");
        chk("tout_revoke", 32'(revoke), 32'd1);
        chk("tout_newgnt", 32'(gnt), 32'h0020);
        for (int i = 0; i < 4; i++) applyStimulus(16'h0028, 1'b0, "tout_hold5");
        chk("tout_back3", 32'(gnt_id), 32'd3);

        doReset(16'h0000, "simul_rst");
        applyStimulus(16'h0080, 1'b0, "simul_g7");
        applyStimulus(16'h0080, 1'b1, "simul_done7");
        chk("simul_idle", 32'(busy), 32'd0);
        applyStimulus(16'h0080, 1'b0, "simul_regrant");
        chk("simul_regrant_id", 32'(gnt_id), 32'd7);
        applyStimulus(16'h0084, 1'b1, "simul_wrap");
        chk("simul_wrap_id", 32'(gnt_id), 32'd2);

        doReset(16'h0000, "mid_rst0");
        applyStimulus(16'h0200, 1'b0, "mid_g9");
        applyStimulus(16'h0200, 1'b0, "mid_g9b");
        #2;
        resetn = 1'b0;
        modelReset();
        #1;
        checkOutput("mid_async");
        chk("mid_async_gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus(16'h0201, 1'b0, "mid_after");
        chk("mid_after_id", 32'(gnt_id), 32'd0);

        for (int i = 0; i < 600; i++) begin
            logic [15:0] r;
            logic        d;
            if ($urandom_range(0, 79) == 0) doReset(16'($urandom), "rand_rst");
            case ($urandom_range(0, 2))
                0:       r = 16'($urandom);
                1:       r = 16'($urandom) & 16'($urandom) & 16'($urandom);
                default: r = 16'h1 << $urandom_range(0, 15);
            endcase
            d = ($urandom_range(0, 3) == 0);
            applyStimulus(r, d, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
